// File: rtl/stop_watch_uart_tx.sv
// Stopwatch time reporter: a rising edge on trig snapshots the count and sends
// "MM:SS.CC\r\n" as 8N1 UART frames. CLKS_PER_BIT must be at least 2.
module stop_watch_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 1085
) (
   input  logic       rst,
   input  logic       clk,
   input  logic [6:0] m_cnt,
   input  logic [5:0] s_cnt,
   input  logic [6:0] us_cnt,
   input  logic       trig,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_CNT  = CW'(CLKS_PER_BIT - 2);
   localparam logic [3:0]    LAST_BYTE = 4'd9;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [3:0]    r_byte, w_byte_nxt;
   logic [6:0]    r_m, r_us;
   logic [5:0]    r_s;
   logic          r_trig_q, r_armed;
   logic          r_tx, r_busy, r_done;
   logic          w_accept, w_tx_nxt;
   logic [7:0]    w_char;
   logic [3:0]    w_m1, w_m0, w_s1, w_s0, w_c1, w_c0;

   // r_armed blocks a trig held high through reset from looking like a new edge
   assign w_accept = trig & ~r_trig_q & r_armed & ~r_busy & (r_state == IDLE);

   assign w_m1 = 4'(r_m / 7'd10);
   assign w_m0 = 4'(r_m % 7'd10);
   assign w_s1 = 4'(r_s / 6'd10);
   assign w_s0 = 4'(r_s % 6'd10);
   assign w_c1 = 4'(r_us / 7'd10);
   assign w_c0 = 4'(r_us % 7'd10);

   always_comb begin
      w_char = 8'h0A;
      case (r_byte)
         4'd0: w_char = {4'h3, w_m1};
         4'd1: w_char = {4'h3, w_m0};
         4'd2: w_char = 8'h3A;
         4'd3: w_char = {4'h3, w_s1};
         4'd4: w_char = {4'h3, w_s0};
         4'd5: w_char = 8'h2E;
         4'd6: w_char = {4'h3, w_c1};
         4'd7: w_char = {4'h3, w_c0};
         4'd8: w_char = 8'h0D;
         default: w_char = 8'h0A;
      endcase
   end

   // STOP ends one cycle early; NEXT fills the last stop-bit cycle so bytes stay back-to-back
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_tx_nxt    = 1'b1;
      case (r_state)
         IDLE: begin
            w_cnt_nxt  = '0;
            w_bit_nxt  = '0;
            w_byte_nxt = '0;
            if (w_accept) w_state_nxt = START;
         end
         START: begin
            w_tx_nxt = 1'b0;
            if (r_cnt == LAST_CNT) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            w_tx_nxt = w_char[r_bit];
            if (r_cnt == LAST_CNT) begin
               w_cnt_nxt = '0;
               w_bit_nxt = r_bit + 1'b1;
               if (r_bit == 3'd7) w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (r_cnt == STOP_CNT) w_state_nxt = NEXT;
         end
         NEXT: begin
            w_cnt_nxt = '0;
            if (r_byte == LAST_BYTE) begin
               w_state_nxt = IDLE;
            end else begin
               w_byte_nxt  = r_byte + 1'b1;
               w_state_nxt = START;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
      end
   end

   // Outputs trail the state by one cycle, which places the first start bit at k+1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trig_q <= 1'b0;
         r_armed  <= 1'b0;
         r_m      <= '0;
         r_s      <= '0;
         r_us     <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_trig_q <= trig;
         r_armed  <= r_armed | ~trig;
         if (w_accept) begin
            r_m  <= (m_cnt  > 7'd99) ? 7'd99 : m_cnt;
            r_s  <= (s_cnt  > 6'd59) ? 6'd59 : s_cnt;
            r_us <= (us_cnt > 7'd99) ? 7'd99 : us_cnt;
         end
         r_tx   <= w_tx_nxt;
         r_busy <= (r_state != IDLE);
         r_done <= (r_state == IDLE) & r_busy;
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule
